// File: rtl/library_pkg.sv
// Shared elaboration helpers for the FIFO slice: depth legality check and
// pointer-width derivation.
package library_pkg;

  // A legal FIFO depth is a power of two of at least 2.
  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: combinational read port, synchronous write port, no reset.
module fifo_mem
  import library_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = ptr_width(DEPTH)
) (
  input  logic              clock,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset branch on purpose; validity of each slot is
  // tracked by the pointers, and a reset here would block RAM inference.
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered count/flags.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module sync_fifo
  import library_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_L,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
`ifdef SYNC_FIFO_ERR_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;
  logic             w_mem_we;

  // Flags come only from the count register, so wr_en/rd_en never reach them.
  assign empty = (r_count == '0);
  assign full  = (r_count == FULL_COUNT);
  assign count = r_count;

  // A full FIFO still takes a push when a pop frees a slot in the same cycle.
  assign w_push   = wr_en & (~full | rd_en);
  assign w_pop    = rd_en & ~empty;
  assign w_mem_we = w_push & reset_L & ~clear;

  fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clock   (clock),
    .i_we    (w_mem_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (rd_data)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clock) begin
    if (!reset_L || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // A simultaneous push keeps an empty-FIFO read from counting as underflow.
  always_ff @(posedge clock) begin
    if (!reset_L || clear) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && full && !rd_en) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && empty && !wr_en) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (WIDTH=8, DEPTH=4): queue-based model,
// per-cycle compare process, directed scenarios and randomized traffic.
module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clock;
  logic             reset_L;
  logic             clear;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             full;
  logic             empty;
  logic [2:0]       count;
`ifdef SYNC_FIFO_ERR_EN
  logic             overflow;
  logic             underflow;
`endif

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clock     (clock),
    .reset_L   (reset_L),
    .clear     (clear),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty),
`ifdef SYNC_FIFO_ERR_EN
    .overflow  (overflow),
    .underflow (underflow),
`endif
    .count     (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model: contents as a queue, error flags as plain bits.
  logic [WIDTH-1:0] m_q[$];
  bit               m_ovf = 1'b0;
  bit               m_udf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies the rules for one clock edge using the inputs seen at that edge.
  task automatic model_edge();
    bit do_push;
    bit do_pop;
    if (!reset_L || clear) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      do_pop  = rd_en && (m_q.size() > 0);
      do_push = wr_en && ((m_q.size() < DEPTH) || rd_en);
      if (wr_en && !rd_en && (m_q.size() == DEPTH)) m_ovf = 1'b1;
      if (rd_en && !wr_en && (m_q.size() == 0))     m_udf = 1'b1;
      if (do_pop)  void'(m_q.pop_front());
      if (do_push) m_q.push_back(wr_data);
    end
  endtask

  task automatic step(input bit rst_n_v, input bit clr_v, input bit we_v,
                      input logic [WIDTH-1:0] wd_v, input bit re_v);
    reset_L = rst_n_v;
    clear   = clr_v;
    wr_en   = we_v;
    wr_data = wd_v;
    rd_en   = re_v;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    step(1'b1, 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic pop();
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic fill_11_44();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("count", 32'(count), 32'(m_q.size()));
      check("empty", 32'(empty), 32'(m_q.size() == 0));
      check("full",  32'(full),  32'(m_q.size() == DEPTH));
      if (m_q.size() != 0) check("rd_data", 32'(rd_data), 32'(m_q[0]));
`ifdef SYNC_FIFO_ERR_EN
      check("overflow",  32'(overflow),  32'(m_ovf));
      check("underflow", 32'(underflow), 32'(m_udf));
`endif
    end
  end

  initial begin
    logic [WIDTH-1:0] exp_seq [4];
    reset_L = 1'b0; clear = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;

    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk_en = 1'b1;
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_full",  32'(full),  32'd0);
    check("reset_count", 32'(count), 32'd0);

    // Fill to full, then drain in order.
    fill_11_44();
    check("fill_full",  32'(full),  32'd1);
    check("fill_count", 32'(count), 32'd4);
    exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      check("drain_data", 32'(rd_data), 32'(exp_seq[i]));
      pop();
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Push while full without pop is dropped.
    fill_11_44();
    push(8'h55);
    check("drop_count", 32'(count), 32'd4);
`ifdef SYNC_FIFO_ERR_EN
    check("drop_overflow", 32'(overflow), 32'd1);
`endif
    for (int i = 0; i < 4; i++) begin
      check("drop_data", 32'(rd_data), 32'(exp_seq[i]));
      pop();
    end
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

    // Push and pop together while full.
    fill_11_44();
    step(1'b1, 1'b0, 1'b1, 8'h66, 1'b1);
    check("fullrw_count", 32'(count), 32'd4);
    exp_seq = '{8'h22, 8'h33, 8'h44, 8'h66};
    for (int i = 0; i < 4; i++) begin
      check("fullrw_data", 32'(rd_data), 32'(exp_seq[i]));
      pop();
    end

    // Push and pop together while empty.
    step(1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
    check("emptyrw_count", 32'(count), 32'd1);
    check("emptyrw_data",  32'(rd_data), 32'h77);
`ifdef SYNC_FIFO_ERR_EN
    check("emptyrw_underflow", 32'(underflow), 32'd0);
`endif
    pop();

    // Pointer wrap with 0x80..0x89 streamed through.
    push(8'h80);
    for (int i = 1; i < 10; i++) begin
      check("wrap_data", 32'(rd_data), 32'(8'h80 + i - 1));
      step(1'b1, 1'b0, 1'b1, 8'(8'h80 + i), 1'b1);
    end
    check("wrap_last", 32'(rd_data), 32'h89);
    pop();

    // Clear with a concurrent push discards everything and drops the flag.
    fill_11_44();
    push(8'h99);
    step(1'b1, 1'b1, 1'b1, 8'hAA, 1'b0);
    check("clear_count", 32'(count), 32'd0);
    check("clear_empty", 32'(empty), 32'd1);
`ifdef SYNC_FIFO_ERR_EN
    check("clear_overflow", 32'(overflow), 32'd0);
`endif

    // Reset mid-stream with three stored words and a pending underflow.
    pop();
    push(8'hA1); push(8'hA2); push(8'hA3);
    check("prerst_count", 32'(count), 32'd3);
    step(1'b0, 1'b0, 1'b1, 8'hA4, 1'b1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
`ifdef SYNC_FIFO_ERR_EN
    check("rst_overflow",  32'(overflow),  32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
`endif
    push(8'h5A);
    check("postrst_data",  32'(rd_data), 32'h5A);
    check("postrst_count", 32'(count),   32'd1);

    // Randomized traffic with phases biased toward filling and draining.
    for (int ph = 0; ph < 8; ph++) begin
      int wr_pct;
      wr_pct = (ph % 2 == 0) ? 75 : 30;
      for (int c = 0; c < 300; c++) begin
        step(($urandom_range(0, 199) != 0),
             ($urandom_range(0, 99) < 2),
             ($urandom_range(0, 99) < wr_pct),
             8'($urandom),
             ($urandom_range(0, 99) < 50));
      end
    end

    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of storage words; power of two, >=2.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_L  input  1  reset, synchronous, active-low.
REQ-005 clear  input  1  synchronous flush, active-high.
REQ-006 wr_en  input  1  push request.
REQ-007 wr_data  input  WIDTH  word to push.
REQ-008 rd_en  input  1  pop request.
REQ-009 rd_data  output  WIDTH  head word (first-word-fall-through).
REQ-010 full  output  1  count == DEPTH.
REQ-011 empty  output  1  count == 0.
REQ-012 count  output  $clog2(DEPTH)+1  words currently stored.
REQ-013 overflow, underflow  output  1 each  sticky error flags; present only with SYNC_FIFO_ERR_EN.

Function
REQ-014 Push accepted when wr_en & (~full | rd_en); the word is stored at the write pointer, which then advances.
REQ-015 Pop accepted when rd_en & ~empty; the read pointer advances and the next word appears on rd_data in the following cycle.
REQ-016 rd_data shall equal the head word combinationally whenever empty == 0; its value when empty == 1 is don't-care.
REQ-017 Write-to-read latency: a word pushed into an empty FIFO shall appear on rd_data with empty == 0 in the cycle after the push edge.
REQ-018 Pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 with no gap.
REQ-019 count: +1 on accepted push only, -1 on accepted pop only, unchanged on both or neither.
REQ-020 Full with wr_en & rd_en: both accepted; count stays DEPTH; the new word lands in the freed slot.
REQ-021 Empty with wr_en & rd_en: pop ignored, push accepted, count becomes 1.
REQ-022 wr_en while full without rd_en: push dropped, storage and pointers unchanged.
REQ-023 rd_en while empty: no pointer or count change.
REQ-024 full, empty and count shall be registered or derived solely from registered state, with no combinational path from wr_en or rd_en.
REQ-025 clear: pointers and count go to 0 on the next edge; storage contents are not cleared; clear overrides same-cycle wr_en and rd_en.

Reset
REQ-026 reset_L == 0 at an edge: pointers = 0, count = 0, empty = 1, full = 0, and error flags = 0 when present.
REQ-027 reset_L has priority over clear, wr_en and rd_en; reset mid-stream discards all stored words.
REQ-028 Storage array is not reset.

Configuration
REQ-029 Macro SYNC_FIFO_ERR_EN defined: overflow sets on a dropped push (REQ-022) and underflow sets on rd_en while empty (REQ-023); both hold until reset_L or clear.
REQ-030 Macro SYNC_FIFO_ERR_EN undefined: the overflow and underflow ports and their logic are absent; all other behaviour is identical.

Structure
REQ-031 Shared package library_pkg holds the DEPTH power-of-two check function and the pointer-width localparam helper.
REQ-032 Storage is one sub-module, fifo_mem: combinational read, synchronous write, write-enable qualified by push acceptance, no reset.
REQ-033 Pointer/count control lives in sync_fifo; no FSM beyond the pointer/count registers.

Verification (WIDTH=8, DEPTH=4, SYNC_FIFO_ERR_EN defined)
REQ-034 After reset, push 0x11, 0x22, 0x33, 0x44 -> full = 1, count = 4; then pop 4 times -> rd_data sequence 0x11, 0x22, 0x33, 0x44, then empty = 1.
REQ-035 While full, wr_en with 0x55 and no rd_en -> count stays 4, overflow = 1, subsequent pops never return 0x55.
REQ-036 While full, wr_en with 0x66 and rd_en together -> 0x11 popped, count stays 4, 0x66 is returned fourth.
REQ-037 While empty, wr_en with 0x77 and rd_en together -> count = 1, rd_data = 0x77 next cycle, underflow stays 0.
REQ-038 Run 10 push/pop pairs (pointer wrap) with data 0x80..0x89 -> order preserved; then assert clear with wr_en -> count = 0, empty = 1, overflow = 0.
REQ-039 With count = 3, drive reset_L = 0 for one edge -> count = 0, empty = 1, full = 0, flags = 0; the next push reads back correctly.
